// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR engine: advance-mode encoding and the
// width-generic next-state function used by the datapath.
package lfsr_pkg;

   localparam logic MODE_FIBONACCI = 1'b0;
   localparam logic MODE_GALOIS    = 1'b1;

   localparam int unsigned MAX_BITS = 32;

   // Operates on a 32-bit container; only the low 'bits' positions are meaningful.
   function automatic logic [MAX_BITS-1:0] lfsr_next(
      input logic [MAX_BITS-1:0] state,
      input logic [MAX_BITS-1:0] taps,
      input logic                mode,
      input int unsigned         bits
   );
      logic [MAX_BITS-1:0] mask;
      logic [MAX_BITS-1:0] shifted;
      logic [4:0]          msb_idx;
      mask    = (bits >= MAX_BITS) ? '1 : ((32'd1 << bits) - 32'd1);
      msb_idx = 5'(bits - 1);
      shifted = (state << 1) & mask;
      if (mode == MODE_FIBONACCI) begin
         lfsr_next = shifted | {31'd0, ^(state & taps & mask)};
      end else begin
         lfsr_next = shifted ^ (state[msb_idx] ? (taps & mask) : '0);
      end
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Run-mode divider: counts 0..TICKS-1 while enabled and pulses tick_o on the
// terminal count; a restart or disable returns the count to zero.
module tick_gen #(
   parameter int unsigned TICKS = 6250
) (
   input  logic clk,
   input  logic reset_i,
   input  logic enable_i,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned   CW   = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign tick_o = enable_i && (count_q == LAST);

   // NOTE: next-state gets a default before any branch so no path leaves it unassigned (no latch).
   always_comb begin
      count_d = count_q;
      if (restart_i || !enable_i || (count_q == LAST)) begin
         count_d = '0;
      end else begin
         count_d = count_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/lfsr_engine.sv
// Width-generic LFSR with run-time taps/seed, Fibonacci or Galois advance,
// zero-state guard and sequence-period measurement.
module lfsr_engine
   import lfsr_pkg::*;
#(
   parameter int unsigned    BITS         = 5,
   parameter int unsigned    TICKS        = 6250,
   parameter logic [BITS-1:0] DEFAULT_TAPS = BITS'(5'b10100),
   parameter int unsigned    COUNT_BITS   = BITS + 1
) (
   input  logic                  clk,
   input  logic                  reset_i,
   input  logic                  run_i,
   input  logic                  step_i,
   input  logic                  mode_i,
   input  logic                  load_seed_i,
   input  logic [BITS-1:0]       seed_i,
   input  logic                  load_taps_i,
   input  logic [BITS-1:0]       taps_i,
   output logic [BITS-1:0]       state_o,
   output logic                  step_o,
   output logic                  lockup_o,
   output logic [COUNT_BITS-1:0] period_o,
   output logic                  period_valid_o
);

   localparam logic [BITS-1:0]       ONE     = BITS'(1);
   localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

   logic [BITS-1:0]       state_q, state_d;
   logic [BITS-1:0]       taps_q, taps_d;
   logic [BITS-1:0]       seed_q, seed_d;
   logic                  lockup_q, lockup_d;
   logic                  adv_q, adv_d;
   logic                  step_q, step_d;
   logic                  valid_q, valid_d;
   logic [COUNT_BITS-1:0] cnt_q, cnt_d;
   logic [COUNT_BITS-1:0] period_q, period_d;

   logic            tick;
   logic            load_any;
   logic            advance;
   logic [BITS-1:0] next_raw;
   logic [BITS-1:0] next_safe;
   logic [BITS-1:0] seed_safe;

   assign load_any  = load_seed_i | load_taps_i;
   assign advance   = (tick | step_i) & ~load_any;
   assign next_raw  = BITS'(lfsr_next(32'(state_q), 32'(taps_q), mode_i, BITS));
   assign next_safe = (next_raw == '0) ? ONE : next_raw;
   assign seed_safe = (seed_i == '0) ? ONE : seed_i;

   tick_gen #(.TICKS(TICKS)) u_tick_gen (
      .clk       (clk),
      .reset_i   (reset_i),
      .enable_i  (run_i),
      .restart_i (load_any | step_i),
      .tick_o    (tick)
   );

   always_comb begin
      state_d  = state_q;
      taps_d   = taps_q;
      seed_d   = seed_q;
      lockup_d = lockup_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      valid_d  = valid_q;
      adv_d    = advance;
      // step_o trails the visible state change by one cycle.
      step_d   = adv_q;

      if (load_seed_i) begin
         state_d  = seed_safe;
         seed_d   = seed_safe;
         lockup_d = (seed_i == '0);
      end
      if (load_taps_i) begin
         taps_d = taps_i;
      end

      if (load_any) begin
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (advance) begin
         state_d = next_safe;
         if (next_raw == '0) begin
            lockup_d = 1'b1;
         end
         // A saturated counter can no longer yield a trustworthy period.
         if ((next_safe == seed_q) && (cnt_q != CNT_MAX)) begin
            period_d = cnt_q + 1'b1;
            valid_d  = 1'b1;
            cnt_d    = '0;
         end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset_i) begin
      if (reset_i) begin
         state_q  <= ONE;
         taps_q   <= DEFAULT_TAPS;
         seed_q   <= ONE;
         lockup_q <= 1'b0;
         adv_q    <= 1'b0;
         step_q   <= 1'b0;
         valid_q  <= 1'b0;
         cnt_q    <= '0;
         period_q <= '0;
      end else begin
         state_q  <= state_d;
         taps_q   <= taps_d;
         seed_q   <= seed_d;
         lockup_q <= lockup_d;
         adv_q    <= adv_d;
         step_q   <= step_d;
         valid_q  <= valid_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
      end
   end

   assign state_o        = state_q;
   assign step_o         = step_q;
   assign lockup_o       = lockup_q;
   assign period_o       = period_q;
   assign period_valid_o = valid_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Self-checking bench for lfsr_engine: directed scenarios plus a randomized
// phase, all compared against an integer-arithmetic reference model.
module tb_lfsr_engine;

   localparam int BITS  = 5;
   localparam int TICKS = 4;
   localparam int CB    = BITS + 1;
   localparam int CMAX  = (1 << CB) - 1;
   localparam int SPAN  = 1 << BITS;

   logic          clk;
   logic          reset_i;
   logic          run_i;
   logic          step_i;
   logic          mode_i;
   logic          load_seed_i;
   logic [BITS-1:0] seed_i;
   logic          load_taps_i;
   logic [BITS-1:0] taps_i;
   logic [BITS-1:0] state_o;
   logic          step_o;
   logic          lockup_o;
   logic [CB-1:0] period_o;
   logic          period_valid_o;

   int checks = 0;
   int errors = 0;

   // Reference model state, plain integers.
   int m_state, m_taps, m_seed, m_cnt, m_period, m_tcnt;
   bit m_lock, m_valid, m_adv1, m_step;

   lfsr_engine #(
      .BITS         (BITS),
      .TICKS        (TICKS),
      .DEFAULT_TAPS (5'b10100),
      .COUNT_BITS   (CB)
   ) dut (
      .clk            (clk),
      .reset_i        (reset_i),
      .run_i          (run_i),
      .step_i         (step_i),
      .mode_i         (mode_i),
      .load_seed_i    (load_seed_i),
      .seed_i         (seed_i),
      .load_taps_i    (load_taps_i),
      .taps_i         (taps_i),
      .state_o        (state_o),
      .step_o         (step_o),
      .lockup_o       (lockup_o),
      .period_o       (period_o),
      .period_valid_o (period_valid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Successor by arithmetic: doubling modulo 2^BITS plus feedback.
   function automatic int ref_next(input int s, input int t, input bit galois);
      int ones;
      int dbl;
      dbl = (s * 2) % SPAN;
      if (!galois) begin
         ones = 0;
         for (int i = 0; i < BITS; i++) begin
            if (((s >> i) & 1) == 1 && ((t >> i) & 1) == 1) ones++;
         end
         return dbl + (ones % 2);
      end
      return dbl ^ ((s >= SPAN / 2) ? t : 0);
   endfunction

   // Number of guarded advances to return to the seed; -1 if never within the counter range.
   function automatic int orbit(input int seed, input int t, input bit galois);
      int s;
      s = seed;
      for (int k = 1; k <= CMAX; k++) begin
         s = ref_next(s, t, galois);
         if (s == 0) s = 1;
         if (s == seed) return k;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_state = 1; m_taps = 'b10100; m_seed = 1; m_cnt = 0; m_period = 0;
      m_tcnt = 0; m_lock = 0; m_valid = 0; m_adv1 = 0; m_step = 0;
   endtask

   task automatic model_edge();
      bit load, tick, adv;
      int nx;
      load = load_seed_i || load_taps_i;
      tick = run_i && (m_tcnt == TICKS - 1);
      adv  = (tick || step_i) && !load;
      if (load || step_i || !run_i || tick) m_tcnt = 0;
      else m_tcnt++;
      m_step = m_adv1;
      m_adv1 = adv;
      if (load_seed_i) begin
         m_state = (seed_i == 0) ? 1 : int'(seed_i);
         m_seed  = m_state;
         m_lock  = (seed_i == 0);
      end
      if (load_taps_i) m_taps = int'(taps_i);
      if (load) begin
         m_cnt = 0; m_valid = 0;
      end else if (adv) begin
         nx = ref_next(m_state, m_taps, mode_i);
         if (nx == 0) begin nx = 1; m_lock = 1; end
         m_state = nx;
         if (nx == m_seed && m_cnt < CMAX) begin
            m_period = m_cnt + 1; m_valid = 1; m_cnt = 0;
         end else if (m_cnt < CMAX) begin
            m_cnt++;
         end
      end
   endtask

   // One clock: update the model from the inputs in force, then sample 1 ns after the edge.
   task automatic cycle();
      if (reset_i) model_reset();
      else model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      check({tag, " state"},  32'(state_o),        32'(m_state));
      check({tag, " step_o"}, 32'(step_o),         32'(m_step));
      check({tag, " lockup"}, 32'(lockup_o),       32'(m_lock));
      check({tag, " period"}, 32'(period_o),       32'(m_period));
      check({tag, " valid"},  32'(period_valid_o), 32'(m_valid));
   endtask

   task automatic load(input bit ls, input int seed, input bit lt, input int taps);
      load_seed_i = ls; seed_i = BITS'(seed);
      load_taps_i = lt; taps_i = BITS'(taps);
      cycle();
      load_seed_i = 0; load_taps_i = 0;
      check_all("load");
   endtask

   task automatic step_once(input string tag);
      step_i = 1;
      cycle();
      step_i = 0;
      check_all(tag);
   endtask

   initial begin
      logic [BITS-1:0] fib_seq [4];
      logic [BITS-1:0] gal_seq [5];
      int n;
      int exp1;
      fib_seq = '{5'b00010, 5'b00100, 5'b01001, 5'b10010};
      gal_seq = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01001};

      reset_i = 1; run_i = 0; step_i = 0; mode_i = 0;
      load_seed_i = 0; seed_i = '0; load_taps_i = 0; taps_i = '0;
      model_reset();
      #2;
      check("reset state",  32'(state_o),        32'd1);
      check("reset lockup", 32'(lockup_o),       32'd0);
      check("reset period", 32'(period_o),       32'd0);
      check("reset valid",  32'(period_valid_o), 32'd0);
      check("reset step_o", 32'(step_o),         32'd0);
      cycle();
      reset_i = 0;
      cycle();
      check_all("post reset");

      // Fibonacci, default taps, single steps with gaps to expose step_o timing.
      mode_i = 0;
      load(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step_i = 1;
         cycle();
         step_i = 0;
         check("fib seq", 32'(state_o), 32'(fib_seq[i]));
         check("fib step_o lag", 32'(step_o), 32'd0);
         cycle();
         check("fib step_o pulse", 32'(step_o), 32'd1);
         cycle();
         check("fib step_o clear", 32'(step_o), 32'd0);
         check_all("fib");
      end
      for (int i = 4; i < 31; i++) step_once("fib run");
      check("fib period", 32'(period_o), 32'd31);
      check("fib valid",  32'(period_valid_o), 32'd1);

      // Galois in run mode with TICKS-cycle spacing.
      mode_i = 1;
      load(1, 1, 1, 'b01001);
      check("gal load clears valid", 32'(period_valid_o), 32'd0);
      run_i = 1;
      for (int k = 0; k < 31; k++) begin
         repeat (TICKS - 1) cycle();
         if (k == 0) check("gal no early advance", 32'(state_o), 32'd1);
         cycle();
         check_all("gal run");
         if (k < 5) check("gal seq", 32'(state_o), 32'(gal_seq[k]));
      end
      check("gal period", 32'(period_o), 32'd31);
      check("gal valid",  32'(period_valid_o), 32'd1);
      check("gal orbit model", 32'(period_o), 32'(orbit(1, 'b01001, 1)));

      // step_i on the tick cycle yields exactly one advance.
      repeat (TICKS - 1) cycle();
      exp1 = ref_next(int'(state_o), 'b01001, 1);
      step_i = 1;
      cycle();
      step_i = 0;
      check("step on tick single", 32'(state_o), 32'(exp1));
      repeat (TICKS - 1) cycle();
      check("after step hold", 32'(state_o), 32'(exp1));
      cycle();
      check_all("after step tick");

      // load_seed_i on the tick cycle suppresses the advance and restarts the divider.
      repeat (TICKS - 1) cycle();
      load(1, 'b10110, 0, 0);
      check("load on tick", 32'(state_o), 32'b10110);
      repeat (TICKS - 1) cycle();
      check("load restart hold", 32'(state_o), 32'b10110);
      cycle();
      check("load restart tick", 32'(state_o), 32'b00101);
      run_i = 0;
      cycle();

      // Lockup guard on seed and on a computed zero.
      load(1, 0, 0, 0);
      check("zero seed state", 32'(state_o), 32'd1);
      check("zero seed lockup", 32'(lockup_o), 32'd1);
      load(1, 1, 1, 0);
      check("nonzero seed clears lockup", 32'(lockup_o), 32'd0);
      for (int i = 0; i < 4; i++) step_once("taps0");
      check("taps0 before zero", 32'(lockup_o), 32'd0);
      step_once("taps0 zero");
      check("taps0 state", 32'(state_o), 32'd1);
      check("taps0 lockup", 32'(lockup_o), 32'd1);
      load(1, 'b00011, 0, 0);
      check("reseed lockup clear", 32'(lockup_o), 32'd0);

      // Non-primitive taps: period from the model's orbit length.
      load(1, 1, 1, 'b00011);
      n = orbit(1, 'b00011, 1);
      for (int i = 0; i < n; i++) step_once("nonprim");
      check("nonprim period", 32'(period_o), 32'(n));
      check("nonprim valid",  32'(period_valid_o), 32'd1);
      run_i = 1;
      repeat (6) cycle();
      load(0, 0, 1, 'b01001);
      check("taps mid-run clears valid", 32'(period_valid_o), 32'd0);
      run_i = 0;

      // An orbit that never revisits the seed saturates the counter.
      load(1, 1, 1, 'b00010);
      for (int i = 0; i < CMAX + 8; i++) step_once("saturate");
      check("saturate valid", 32'(period_valid_o), 32'd0);

      // Asynchronous reset between edges while running.
      mode_i = 0;
      load(1, 'b01101, 0, 0);
      run_i = 1;
      repeat (9) cycle();
      reset_i = 1;
      #2;
      check("async state",  32'(state_o),        32'd1);
      check("async lockup", 32'(lockup_o),       32'd0);
      check("async period", 32'(period_o),       32'd0);
      check("async valid",  32'(period_valid_o), 32'd0);
      check("async step_o", 32'(step_o),         32'd0);
      model_reset();
      @(posedge clk);
      #1;
      reset_i = 0;
      repeat (TICKS - 1) cycle();
      check("post reset hold", 32'(state_o), 32'd1);
      cycle();
      check("post reset first tick", 32'(state_o), 32'd2);
      check_all("post reset run");

      // Randomized phase.
      for (int i = 0; i < 400; i++) begin
         run_i       = ($urandom_range(3) == 0);
         step_i      = ($urandom_range(2) == 0);
         mode_i      = 1'($urandom);
         load_seed_i = ($urandom_range(19) == 0);
         seed_i      = BITS'($urandom);
         load_taps_i = ($urandom_range(24) == 0);
         taps_i      = BITS'($urandom);
         cycle();
         check_all("random");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_engine.md
Name: lfsr_engine

Overview:
- Parametrised successor of the 5-bit display LFSR: a width-generic LFSR with run-time taps, seed, Fibonacci/Galois mode, free-run or single-step advance, lockup recovery and period measurement.
- Sits between the io_in decode logic and the seven_segment/output stage of a top module.
- Lets one top instance sweep polynomials and read back the achieved sequence period.

Parameters:
- BITS, 5, LFSR width; legal 2..32.
- TICKS, 6250, clk cycles per automatic step in run mode; legal >= 1; 1 = step every cycle.
- DEFAULT_TAPS, 5'b10100 (sized to BITS), taps register value after reset.
- COUNT_BITS, BITS+1, width of period counter.

Ports:
- clk  input  1  clock, rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- run_i  input  1  1 = advance automatically every TICKS cycles.
- step_i  input  1  single-cycle request: advance once on the next edge.
- mode_i  input  1  0 = Fibonacci, 1 = Galois; sampled at each advance.
- load_seed_i  input  1  load seed_i into state.
- seed_i  input  BITS  seed value.
- load_taps_i  input  1  load taps_i into taps register.
- taps_i  input  BITS  tap mask.
- state_o  output  BITS  current LFSR state.
- step_o  output  1  one-cycle pulse in the cycle after state_o changed by an advance.
- lockup_o  output  1  sticky flag: a zero state was suppressed.
- period_o  output  COUNT_BITS  measured period.
- period_valid_o  output  1  period_o holds a completed measurement.

Behaviour:
- Reset (async assert, sync release): state = 1, taps = DEFAULT_TAPS, seed_reg = 1, tick counter = 0, step counter = 0, step_o = 0, lockup_o = 0, period_o = 0, period_valid_o = 0.
- Advance function from state S and taps T:
  - Fibonacci: fb = XOR-reduce(S & T); next = {S[BITS-2:0], fb}.
  - Galois: next = {S[BITS-2:0], 0} ^ (S[BITS-1] ? T : 0).
- Zero guard: if a loaded seed or a computed next state is all-zero, store 1 instead and set lockup_o. lockup_o clears only on load_seed_i with a nonzero seed, or on reset.
- Tick generator: counts 0..TICKS-1 while run_i = 1 and emits tick on the terminal count. It holds at 0 while run_i = 0. Any load or step_i restarts it from 0.
- Advance condition: tick OR step_i. Advances are not queued: a step_i coinciding with a tick gives one advance.
- Priority within a cycle, highest first:
  - reset_i.
  - load_seed_i / load_taps_i: both may occur together; any load suppresses an advance that cycle.
  - advance.
- Taps take effect on the first advance after the load cycle. Seed load also copies the stored value into seed_reg.
- step_o is registered: high exactly one cycle after each advance edge. Latency is 1 cycle from step_i to state_o and 1 more cycle to step_o.
- Period measurement:
  - The step counter is cleared by load_seed_i and load_taps_i, and clears period_valid_o.
  - Each advance increments the step counter, saturating at all-ones.
  - When an advance produces next == seed_reg and the counter is not saturated, period_o = counter + 1 and period_valid_o = 1. The counter then restarts at 0, so subsequent wraps re-measure.
  - If the counter saturates, period_valid_o stays 0 until the next load.
- Reset mid-count: all counters and flags return to reset values immediately. No partial period is reported.

Decomposition:
- Package lfsr_pkg: mode constants MODE_FIBONACCI = 0, MODE_GALOIS = 1, and a function lfsr_next(state, taps, mode) shared with the testbench model.
- Sub-module tick_gen (parameter TICKS; ports clk, reset_i, enable_i, restart_i, tick_o) holds the divider.
- The state, taps and period logic stay in lfsr_engine.

Test Plan:
- Galois: BITS=5, TICKS=1, load taps 5'b01001, seed 5'b00001, then run -> state_o sequence 00010, 00100, 01000, 10000, 01001; period_o = 31 with period_valid_o = 1 after the 31st advance.
- Fibonacci: taps 5'b10100, seed 00001, repeated step_i pulses -> 00010, 00100, 01001, 10010. Period 31. step_o pulses exactly once per step_i, one cycle late.
- Lockup: load seed 0 -> state_o = 1, lockup_o = 1. Load taps 0 in Galois and advance 5 times -> zero suppressed, state_o = 1, lockup_o stays 1. Load seed 00011 -> lockup_o = 0.
- Non-primitive taps: Galois taps 5'b00011 from seed 1 -> period_o equals the software-model value and period_valid_o asserts. Loading taps mid-run clears period_valid_o.
- Timing: TICKS=4, run_i = 1 -> advances every 4 cycles. A step_i on a tick cycle gives a single advance. A load_seed_i on a tick cycle gives no advance and the next tick comes 4 cycles later.
- Async reset asserted mid-run, between edges -> outputs reach reset values without a clock edge. After release, the first advance occurs TICKS cycles later.
